pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 123 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_seq_pkg : state encoding and default timing for the PLL reset    |
// | sequencer.                                         Revision 1.0      |
// +----------------------------------------------------------------------+
package pll_seq_pkg;

   localparam int DEF_RST_CYCLES          = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
   localparam int DEF_MAX_RETRIES         = 3;

   localparam logic [2:0] ST_PLL_RST   = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_FAULT     = 3'd4;

   // Same encoding as an enum, for waveform decoding.
   typedef enum logic [2:0] {
      E_PLL_RST   = ST_PLL_RST,
      E_WAIT_LOCK = ST_WAIT_LOCK,
      E_STABLE    = ST_STABLE,
      E_RUN       = ST_RUN,
      E_FAULT     = ST_FAULT
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : 1-bit two-flop synchronizer, synchronous reset to 0.      |
// |                                                    Revision 1.0      |
// +----------------------------------------------------------------------+
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_reset_sequencer : PLL reset/lock bring-up FSM with timeout,      |
// | bounded retries and lock-loss recovery.            Revision 1.0      |
// +----------------------------------------------------------------------+
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES          = DEF_RST_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
   localparam int RETRY_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1)
)
(
   input  logic               clkin,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               restart,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fault,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam int CNT_MAX = max3(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   logic               locked_s;
   logic [2:0]         state;
   logic [2:0]         state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry_nx;
   logic               lost_nx;

   sync_2ff u_sync (
      .clk (clkin),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   always_comb begin
      state_nx = state;
      retry_nx = retry_cnt;
      lost_nx  = 1'b0;
      if (restart) begin
         state_nx = ST_PLL_RST;
         retry_nx = '0;
      end else begin
         case (state)
            ST_PLL_RST: begin
               if (cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (locked_s) begin
                  state_nx = ST_STABLE;
               end else if (cnt == TIMEOUT_LAST) begin
                  // Out of retries: park in FAULT; otherwise pulse PLL reset again.
                  if (retry_cnt >= RETRY_MAX) begin
                     state_nx = ST_FAULT;
                  end else begin
                     state_nx = ST_PLL_RST;
                     retry_nx = retry_cnt + 1'b1;
                  end
               end
            end
            ST_STABLE: begin
               if (!locked_s)                state_nx = ST_WAIT_LOCK;
               else if (cnt == STABLE_LAST)  state_nx = ST_RUN;
            end
            ST_RUN: begin
               if (!locked_s) begin
                  state_nx = ST_PLL_RST;
                  retry_nx = '0;
                  lost_nx  = 1'b1;
               end
            end
            ST_FAULT: begin
               state_nx = ST_FAULT;
            end
            default: begin
               state_nx = ST_PLL_RST;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they change with the state.
   always_ff @(posedge clkin) begin
      if (rst) begin
         state     <= ST_PLL_RST;
         cnt       <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         state     <= state_nx;
         retry_cnt <= retry_nx;
         if (restart || (state_nx != state))
            cnt <= '0;
         else if ((state != ST_RUN) && (state != ST_FAULT))
            cnt <= cnt + 1'b1;
         pll_rst   <= (state_nx == ST_PLL_RST) || (state_nx == ST_FAULT);
         sys_rst   <= (state_nx != ST_RUN);
         ready     <= (state_nx == ST_RUN);
         fault     <= (state_nx == ST_FAULT);
         lock_lost <= lost_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_pll_reset_sequencer : scoreboard bench with a phase-level model.  |
// |                                                    Revision 1.0      |
// +----------------------------------------------------------------------+
module tb_pll_reset_sequencer;

   localparam int RST_C = 4;
   localparam int LS_C  = 8;
   localparam int TO_C  = 32;
   localparam int MAX_R = 2;
   localparam int MAXN  = 400;

   localparam int PH_RST  = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_STB  = 2;
   localparam int PH_RUN  = 3;
   localparam int PH_FLT  = 4;

   logic       clkin = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst, sys_rst, ready, fault, lock_lost;
   logic [1:0] retry_cnt;

   pll_reset_sequencer #(
      .RST_CYCLES          (RST_C),
      .LOCK_STABLE_CYCLES  (LS_C),
      .LOCK_TIMEOUT_CYCLES (TO_C),
      .MAX_RETRIES         (MAX_R)
   ) dut (
      .clkin      (clkin),
      .rst        (rst),
      .pll_locked (pll_locked),
      .restart    (restart),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .lock_lost  (lock_lost),
      .retry_cnt  (retry_cnt)
   );

   always #20 clkin = ~clkin;

   typedef struct {
      int         tag;
      logic [6:0] v;
   } rec_t;

   rec_t       sb[$];
   rec_t       mrec;
   int         edge_no = 0;
   int         checks  = 0;
   int         errors  = 0;
   bit         p  [0:MAXN];
   bit         rs [0:MAXN];
   bit         lk [0:MAXN];
   logic [6:0] ex [0:MAXN];

   // {pll_rst, sys_rst, ready, fault} for each phase of the bring-up.
   function automatic logic [3:0] phase_bits(input int ph);
      case (ph)
         PH_RST:  return 4'b1100;
         PH_RUN:  return 4'b0010;
         PH_FLT:  return 4'b1101;
         default: return 4'b0100;
      endcase
   endfunction

   // Walks whole phases, finding each exit edge by searching the lock and
   // restart traces, then fills the expected outputs for the phase span.
   task automatic build_model(input int nl);
      int t, e, ph, nph, rt, nrt;
      bit ll, nll;
      for (int k = 0; k <= nl; k++) lk[k] = (k >= 3) ? p[k-2] : 1'b0;
      t = 0; ph = PH_RST; rt = 0; ll = 1'b0;
      while (t <= nl) begin
         nll = 1'b0; nrt = rt; e = nl + 1; nph = ph;
         case (ph)
            PH_RST: begin
               e = t + RST_C; nph = PH_WAIT;
            end
            PH_WAIT: begin
               e   = t + TO_C;
               nph = (rt == MAX_R) ? PH_FLT : PH_RST;
               nrt = (rt == MAX_R) ? rt : rt + 1;
               for (int k = t + 1; k <= t + TO_C && k <= nl; k++)
                  if (lk[k]) begin e = k; nph = PH_STB; nrt = rt; break; end
            end
            PH_STB: begin
               e = t + LS_C; nph = PH_RUN;
               for (int k = t + 1; k <= t + LS_C && k <= nl; k++)
                  if (!lk[k]) begin e = k; nph = PH_WAIT; break; end
            end
            PH_RUN: begin
               for (int k = t + 1; k <= nl; k++)
                  if (!lk[k]) begin e = k; nph = PH_RST; nrt = 0; nll = 1'b1; break; end
            end
            default: ;
         endcase
         for (int k = t + 1; k <= e && k <= nl; k++)
            if (rs[k]) begin e = k; nph = PH_RST; nrt = 0; nll = 1'b0; break; end
         for (int k = t; k < e && k <= nl; k++)
            ex[k] = {phase_bits(ph), (ll && (k == t)), rt[1:0]};
         t = e; ph = nph; rt = nrt; ll = nll;
      end
   endtask

   task automatic clr(input int nl);
      for (int k = 0; k <= nl; k++) begin
         p[k]  = 1'b0;
         rs[k] = 1'b0;
      end
      p[0] = 1'($urandom_range(0, 1));
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
      edge_no++;
   endtask

   // Scenario edge 0 is a reset edge; expectations are queued before driving.
   task automatic run_scen(input int nl);
      build_model(nl);
      for (int k = 0; k <= nl; k++) sb.push_back('{tag: edge_no + 1 + k, v: ex[k]});
      for (int k = 0; k <= nl; k++) begin
         rst        = (k == 0);
         restart    = rs[k];
         pll_locked = p[k];
         tick();
      end
      restart = 1'b0;
   endtask

   always @(negedge clkin) begin
      while (sb.size() > 0 && sb[0].tag <= edge_no) begin
         mrec = sb.pop_front();
         checks++;
         if (mrec.tag != edge_no) begin
            errors++;
            $display("FAIL stale_expect edge=%0d got_edge=%0d", mrec.tag, edge_no);
         end else if ({pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt} !== mrec.v) begin
            errors++;
            $display("FAIL outputs edge=%0d got {pll_rst,sys_rst,ready,fault,lock_lost,retry}=%b want=%b",
                     edge_no, {pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt}, mrec.v);
         end
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog expired at edge %0d", edge_no);
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      bit v;
      tick();
      tick();

      // Normal bring-up.
      clr(40);
      for (int k = 10; k <= 40; k++) p[k] = 1'b1;
      run_scen(40);

      // Glitchy lock.
      clr(50);
      for (int k = 10; k <= 14; k++) p[k] = 1'b1;
      for (int k = 17; k <= 50; k++) p[k] = 1'b1;
      run_scen(50);

      // Timeouts into FAULT, then restart and recover.
      clr(170);
      rs[120] = 1'b1;
      for (int k = 125; k <= 170; k++) p[k] = 1'b1;
      run_scen(170);

      // Lock loss in RUN, then relock; ends in RUN with lock high.
      clr(100);
      for (int k = 5; k <= 40; k++) p[k] = 1'b1;
      for (int k = 60; k <= 100; k++) p[k] = 1'b1;
      run_scen(100);

      // Leave the DUT in STABLE.
      clr(10);
      for (int k = 3; k <= 10; k++) p[k] = 1'b1;
      run_scen(10);

      // rst together with restart, then restart alone during WAIT_LOCK.
      clr(60);
      rs[0]  = 1'b1;
      rs[15] = 1'b1;
      for (int k = 30; k <= 60; k++) p[k] = 1'b1;
      run_scen(60);

      // Randomized lock traces with occasional restarts.
      for (int s = 0; s < 12; s++) begin
         clr(200);
         v   = 1'($urandom_range(0, 1));
         len = 0;
         for (int k = 1; k <= 200; k++) begin
            if (len == 0) begin
               v   = ~v;
               len = v ? $urandom_range(1, 60) : $urandom_range(1, 45);
            end
            p[k] = v;
            len--;
            rs[k] = ($urandom_range(0, 99) == 0);
         end
         rs[0] = ($urandom_range(0, 3) == 0);
         run_scen(200);
      end

      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
